// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment display driver.
//   state_e   : driver FSM states (BLANK, SHOW, LAMP)
//   SEG_BLANK : all segments and DP off
//   SEG_ALL   : all segments and DP on (lamp test)
//   HEX_SEG   : hex digit -> segments {g,f,e,d,c,b,a}, active-high
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SHOW  = 2'd1,
    ST_LAMP  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL   = 8'hFF;

  // Packed table; entry 15 sits first in the concatenation.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex digit to 7-segment lookup.
//   digit : 4-bit value 0x0-0xF
//   seg   : segments a..g on bits 0..6, active-high
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[digit];

endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: holds a digit received over valid/ready and drives a
// registered 7-segment pattern with brightness PWM, a decimal point that
// blinks on the 1 Hz tick, and a lamp-test override.
//   clk, reset   : clock, synchronous active-high reset
//   digit_in     : 4-bit digit, qualified by digit_valid
//   digit_ready  : high when a digit can be accepted (not in lamp test)
//   tick_1hz     : one-cycle pulse per second, toggles DP while showing
//   brightness   : PWM duty; 0 = off, all-ones = always on
//   lamp_test    : level; forces all segments and DP on
//   seg_out      : registered {dp, g..a}, active-high
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          digit_in,
  input  logic                digit_valid,
  output logic                digit_ready,
  input  logic                tick_1hz,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                lamp_test,
  output logic [7:0]          seg_out
);

  localparam logic [PWM_BITS-1:0] PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [3:0]          digit_q, digit_d;
  logic                have_q, have_d;
  logic                dp_q, dp_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          seg_out_q, seg_out_d;
  logic                accept;
  logic                pwm_on;
  logic [6:0]          seg_pat;

  seg7_decode u_decode (
    .digit (digit_q),
    .seg   (seg_pat)
  );

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    have_d    = have_q;
    dp_d      = dp_q;
    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    seg_out_d = SEG_BLANK;

    digit_ready = (state_q != ST_LAMP);
    accept      = digit_valid & digit_ready;
    pwm_on      = (pwm_cnt_q < brightness) | (&brightness);

    // Ready is still high on the cycle lamp_test rises, so a digit offered
    // then is taken even though the state moves to LAMP.
    if (accept) begin
      digit_d = digit_in;
      have_d  = 1'b1;
    end

    // DP only blinks while a digit is being shown; it is frozen in LAMP.
    if (state_q == ST_SHOW && tick_1hz)
      dp_d = ~dp_q;

    case (state_q)
      ST_BLANK: begin
        if (lamp_test)   state_d = ST_LAMP;
        else if (accept) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (lamp_test)   state_d = ST_LAMP;
      end
      ST_LAMP: begin
        if (!lamp_test)  state_d = have_q ? ST_SHOW : ST_BLANK;
      end
      default:           state_d = ST_BLANK;
    endcase

    // Output reflects the state registered at this edge, giving the
    // two-edge latency from an input event to seg_out.
    case (state_q)
      ST_LAMP:  seg_out_d = SEG_ALL;
      ST_SHOW:  seg_out_d = pwm_on ? {dp_q, seg_pat} : SEG_BLANK;
      default:  seg_out_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_BLANK;
      digit_q   <= 4'h0;
      have_q    <= 1'b0;
      dp_q      <= 1'b0;
      pwm_cnt_q <= '0;
      seg_out_q <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      have_q    <= have_d;
      dp_q      <= dp_d;
      pwm_cnt_q <= pwm_cnt_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver: directed scenarios plus a
// randomized run, all checked against a behavioural model of the display.
module tb_seg7_display_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       tick_1hz;
  logic [3:0] brightness;
  logic       lamp_test;
  logic [7:0] seg_out;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model: mode 0 = blank, 1 = showing, 2 = lamp test.
  int         m_mode, m_digit, m_cyc;
  bit         m_have, m_dp;
  logic [7:0] exp_seg;
  logic       exp_ready;

  seg7_display_driver #(.PWM_BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .tick_1hz    (tick_1hz),
    .brightness  (brightness),
    .lamp_test   (lamp_test),
    .seg_out     (seg_out)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_hex(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
     12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Advance one clock edge; the model applies the same edge to its own
  // abstract state, then outputs are sampled 1 time unit later.
  task automatic step();
    bit acc, on;
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_digit = 0; m_have = 0; m_dp = 0; m_cyc = 0;
      exp_seg = 8'h00;
    end else begin
      on = ((m_cyc % 16) < int'(brightness)) || (brightness == 4'd15);
      if (m_mode == 2)      exp_seg = 8'hFF;
      else if (m_mode == 0) exp_seg = 8'h00;
      else                  exp_seg = on ? {m_dp, ref_hex(m_digit)} : 8'h00;
      acc = digit_valid && (m_mode != 2);
      if (tick_1hz && m_mode == 1) m_dp = !m_dp;
      if (acc) begin m_digit = int'(digit_in); m_have = 1; end
      if (lamp_test && m_mode != 2)       m_mode = 2;
      else if (m_mode == 2 && !lamp_test) m_mode = m_have ? 1 : 0;
      else if (m_mode == 0 && acc)        m_mode = 1;
      m_cyc++;
    end
    exp_ready = (m_mode != 2);
    #1;
  endtask

  task automatic idle_inputs();
    digit_valid = 0; tick_1hz = 0; lamp_test = 0; reset = 0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in = d; digit_valid = 1;
    step();
    digit_valid = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs(); brightness = 4'hF; digit_in = 0; reset = 1;
    step(); step();
    reset = 0;
    tests_run++;
    if (seg_out !== 8'h00) begin tests_failed++; $display("FAIL reset_seg got %h want 00", seg_out); end
    tests_run++;
    if (digit_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", digit_ready); end
    for (int i = 0; i < 6; i++) begin
      tick_1hz = (i % 2 == 0);
      step();
    end
    tick_1hz = 0;
    step(); step();
    tests_run++;
    if (seg_out !== 8'h00) begin tests_failed++; $display("FAIL blank_ticks got %h want 00", seg_out); end
  endtask

  task automatic test_digit();
    brightness = 4'hF; digit_in = 4'd3; digit_valid = 1;
    step();
    digit_valid = 0;
    tests_run++;
    if (seg_out !== 8'h00) begin tests_failed++; $display("FAIL digit_latency_n got %h want 00", seg_out); end
    step();
    tests_run++;
    if (seg_out !== 8'h4F) begin tests_failed++; $display("FAIL digit_show got %h want 4F", seg_out); end
  endtask

  task automatic test_ticks();
    logic [7:0] want [3] = '{8'hCF, 8'h4F, 8'hCF};
    for (int k = 0; k < 3; k++) begin
      tick_1hz = 1;
      step();
      tick_1hz = 0;
      tests_run++;
      if (seg_out !== (k == 1 ? 8'hCF : 8'h4F)) begin
        tests_failed++; $display("FAIL tick%0d_early got %h want %h", k, seg_out, (k == 1 ? 8'hCF : 8'h4F));
      end
      step();
      tests_run++;
      if (seg_out !== want[k]) begin tests_failed++; $display("FAIL tick%0d got %h want %h", k, seg_out, want[k]); end
    end
  endtask

  task automatic test_pwm();
    int on_cnt, bad;
    tick_1hz = 1; step(); tick_1hz = 0;   // dp back to 0
    brightness = 4'd4;
    send_digit(4'd8);
    on_cnt = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (seg_out === 8'h7F) on_cnt++;
      else if (seg_out !== 8'h00) bad++;
      if (seg_out !== exp_seg) bad++;
    end
    tests_run++;
    if (on_cnt != 8 || bad != 0) begin
      tests_failed++; $display("FAIL pwm_b4 on=%0d bad=%0d want on=8 bad=0", on_cnt, bad);
    end
    brightness = 4'd0;
    step();
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (seg_out !== 8'h00) on_cnt++;
    end
    tests_run++;
    if (on_cnt != 0) begin tests_failed++; $display("FAIL pwm_b0 nonzero=%0d want 0", on_cnt); end
  endtask

  task automatic test_lamp();
    brightness = 4'hF;
    send_digit(4'd3);
    step();
    tests_run++;
    if (seg_out !== 8'h4F) begin tests_failed++; $display("FAIL lamp_pre got %h want 4F", seg_out); end
    lamp_test = 1;
    step();
    tests_run++;
    if (digit_ready !== 1'b0) begin tests_failed++; $display("FAIL lamp_ready got %b want 0", digit_ready); end
    step();
    tests_run++;
    if (seg_out !== 8'hFF) begin tests_failed++; $display("FAIL lamp_on got %h want FF", seg_out); end
    digit_in = 4'd5; digit_valid = 1; tick_1hz = 1;
    step(); step(); step();
    digit_valid = 0; tick_1hz = 0;
    tests_run++;
    if (seg_out !== 8'hFF || digit_ready !== 1'b0) begin
      tests_failed++; $display("FAIL lamp_hold got %h/%b want FF/0", seg_out, digit_ready);
    end
    lamp_test = 0;
    step(); step();
    tests_run++;
    if (seg_out !== 8'h4F || digit_ready !== 1'b1) begin
      tests_failed++; $display("FAIL lamp_exit got %h/%b want 4F/1", seg_out, digit_ready);
    end
  endtask

  task automatic test_reset_mid();
    tick_1hz = 1; step(); tick_1hz = 0; step();
    tests_run++;
    if (seg_out !== 8'hCF) begin tests_failed++; $display("FAIL mid_dp got %h want CF", seg_out); end
    reset = 1; step(); reset = 0;
    tests_run++;
    if (seg_out !== 8'h00 || digit_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset got %h/%b want 00/1", seg_out, digit_ready);
    end
    for (int i = 0; i < 8; i++) begin tick_1hz = (i % 3 == 0); step(); end
    tick_1hz = 0;
    tests_run++;
    if (seg_out !== 8'h00) begin tests_failed++; $display("FAIL mid_ticks got %h want 00", seg_out); end
    send_digit(4'hA);
    tests_run++;
    if (seg_out !== 8'h77) begin tests_failed++; $display("FAIL mid_new got %h want 77", seg_out); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    // accept + tick together, then lamp rising with a digit offered
    digit_in = 4'hE; digit_valid = 1; tick_1hz = 1; step();
    digit_valid = 0; tick_1hz = 0; step();
    if (seg_out !== exp_seg) bad++;
    tests_run++;
    if (seg_out !== 8'hF9) begin tests_failed++; $display("FAIL acc_tick got %h want F9", seg_out); end
    digit_in = 4'h1; digit_valid = 1; lamp_test = 1; step();
    digit_valid = 0; step(); step();
    lamp_test = 0; step(); step();
    tests_run++;
    if (seg_out !== 8'h86) begin tests_failed++; $display("FAIL lamp_acc got %h want 86", seg_out); end
    for (int i = 0; i < 16; i++) begin
      digit_in = 4'(i); digit_valid = 1; step();
      if (seg_out !== exp_seg) bad++;
    end
    digit_valid = 0;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL back_to_back mismatches=%0d want 0", bad); end
  endtask

  task automatic test_random();
    int bad_seg = 0, bad_rdy = 0;
    logic [7:0] first_got = 8'h00, first_exp = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      digit_in    = 4'($urandom);
      digit_valid = ($urandom_range(0, 3) == 0);
      tick_1hz    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) lamp_test = !lamp_test;
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
      step();
      if (seg_out !== exp_seg) begin
        if (bad_seg == 0) begin first_got = seg_out; first_exp = exp_seg; end
        bad_seg++;
      end
      if (digit_ready !== exp_ready) bad_rdy++;
    end
    idle_inputs();
    tests_run++;
    if (bad_seg != 0) begin
      tests_failed++; $display("FAIL random_seg mismatches=%0d first got %h want %h", bad_seg, first_got, first_exp);
    end
    tests_run++;
    if (bad_rdy != 0) begin tests_failed++; $display("FAIL random_ready mismatches=%0d want 0", bad_rdy); end
  endtask

  initial begin
    test_reset();
    test_digit();
    test_ticks();
    test_pwm();
    test_lamp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Downstream stage of the top-level seconds/digit counter. Accepts a 4-bit digit over a valid/ready handshake, holds it, and decodes it to a 7-segment pattern on the display outputs. Also provides brightness PWM, a decimal point that blinks on the 1 Hz tick, and a lamp-test override. The top level connects `seg_out` directly to `uo_out`.

## Interface
- `PWM_BITS`, default 4: width of the brightness PWM counter and of the `brightness` input.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `digit_in` input 4: digit value 0x0–0xF from the upstream counter.
- `digit_valid` input 1: `digit_in` is valid this cycle.
- `digit_ready` output 1: the driver can accept a digit.
- `tick_1hz` input 1: one-cycle pulse, once per second, from upstream.
- `brightness` input PWM_BITS: duty-cycle setting.
  - 0 = off.
  - all-ones = continuously on.
- `lamp_test` input 1: level; while high, all segments and DP are forced on.
- `seg_out` output 8: registered, active-high.
  - bit0..bit6 = segments a..g.
  - bit7 = decimal point.

## Operation
- States:
  - BLANK: no digit received since reset.
  - SHOW: digit held.
  - LAMP: lamp test active.
- Transitions, evaluated each rising edge, with priority in the listed order:
  - Any state: reset → BLANK.
  - BLANK or SHOW with `lamp_test`=1 → LAMP.
  - LAMP with `lamp_test`=0 → SHOW if `have_digit`=1, else BLANK.
  - BLANK with accept → SHOW.
  - Otherwise the state holds.
- `digit_ready` is combinational: it is 1 in BLANK and SHOW, and 0 in LAMP.
- Accept = `digit_valid` & `digit_ready`. On accept, `digit_in` loads into `digit_reg` and `have_digit` is set to 1.
- In LAMP, `digit_valid` is ignored. `digit_reg`, `have_digit` and `dp` are retained.
- Decode is hex. Values 0..F map to 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- DP behaviour:
  - `dp` toggles on each `tick_1hz` while in SHOW.
  - In BLANK, `tick_1hz` is ignored and `dp` stays 0.
  - In LAMP, `tick_1hz` is ignored.
- PWM:
  - `pwm_cnt` is a free-running PWM_BITS counter that increments every cycle and wraps 2^PWM_BITS−1 → 0.
  - `pwm_on` = (`pwm_cnt` < `brightness`) | (`brightness` == all-ones).
- `seg_out` next value:
  - LAMP: 0xFF, ignoring PWM.
  - BLANK: 0x00.
  - SHOW: {`dp`, decode(`digit_reg`)} when `pwm_on`, else 0x00.
- Simultaneous events:
  - Accept and `tick_1hz` in the same cycle in SHOW: both take effect, i.e. the new digit loads and `dp` toggles.
  - Accept and `tick_1hz` in the same cycle in BLANK: the digit is accepted and `dp` stays 0.
  - `lamp_test` rising in the same cycle as `digit_valid` in SHOW or BLANK: the digit is accepted, because `digit_ready` is still 1, and the state goes to LAMP.
- Reset clears everything: state = BLANK, `digit_reg` = 0, `have_digit` = 0, `dp` = 0, `pwm_cnt` = 0, `seg_out` = 0x00. This applies equally mid-SHOW and mid-LAMP.

## Timing
- Reset values:
  - `seg_out` = 0x00.
  - `digit_ready` = 1 from the first cycle after reset, since the state is BLANK.
- Digit latency: an accept sampled at edge N loads `digit_reg` at N. The new pattern appears on `seg_out` after edge N+1.
- Tick latency: `tick_1hz` sampled at edge N toggles `dp` at N; `seg_out` bit7 changes after edge N+1.
- Lamp-test entry: `lamp_test` sampled high at edge N sets state LAMP at N; `seg_out` = 0xFF after edge N+1.
- Lamp-test exit: same 2-edge timing as entry.
- `digit_ready` falls in the cycle after the edge that enters LAMP.
- PWM period is 2^PWM_BITS cycles. With PWM_BITS=4 and `brightness`=b (b<15), `seg_out` is non-zero exactly b of every 16 cycles in SHOW.

## Structure
- Shared package `seg7_pkg`:
  - state enum (BLANK, SHOW, LAMP);
  - constants `SEG_BLANK`=8'h00 and `SEG_ALL`=8'hFF;
  - the 16-entry hex segment table.
- Sub-module `seg7_decode`: combinational 4-bit → 7-bit lookup using the package table. It is instantiated once.
- Top of the block: FSM, handshake, `dp` toggle, PWM counter, output register.

## Test plan
- Reset → `seg_out`=0x00 and `digit_ready`=1. With no digit sent, `tick_1hz` pulses leave `seg_out`=0x00.
- `brightness`=0xF, send `digit_in`=3 with valid at edge N → `seg_out`=0x4F after N+1.
- In SHOW with digit 3, three `tick_1hz` pulses → `seg_out` goes 0xCF, 0x4F, 0xCF, each change 2 edges after its tick.
- `brightness`=4 with digit 8 → `seg_out`=0x7F for exactly 4 of every 16 cycles and 0x00 for the other 12. `brightness`=0 → constant 0x00.
- Assert `lamp_test` → `seg_out`=0xFF and `digit_ready`=0. Drive `digit_valid` with digit 5 → ignored. Release → `seg_out` returns to 0x4F (digit 3) with `dp` preserved.
- Reset while in SHOW with `dp`=1 → next cycle `seg_out`=0x00 and state BLANK. Subsequent ticks keep `seg_out`=0x00 until a new digit is sent.
